serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single one-bit full-adder cell plus a carry flip-flop.
- Loads two WIDTH-bit operands and a carry-in on a start pulse, then adds one bit per clock, LSB first.
- Presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Area-saving alternative to ripple adders in the arithmetic datapath; trades latency for a single adder cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; accepted only in IDLE
- A  input  WIDTH  operand A; sampled on the accepting edge only
- B  input  WIDTH  operand B; sampled on the accepting edge only
- Cin  input  1  carry-in; sampled on the accepting edge only
- busy  output  1  high while bits are being processed (SHIFT state)
- done  output  1  one-cycle pulse; Sum/Cout are valid from this cycle on
- Sum  output  WIDTH  registered result, held until the next completion
- Cout  output  1  registered final carry, held with Sum

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, Sum=0, Cout=0. Internal operand/sum shift registers, carry flop and bit counter are also cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, with start=1 at edge k:
  - load opA<=A, opB<=B, carry<=Cin, cnt<=0; go to SHIFT.
  - A, B and Cin may change freely after edge k.
- SHIFT, each edge:
  - s = opA[0]^opB[0]^carry; c = (opA[0]&opB[0]) | ((opA[0]^opB[0])&carry).
  - acc <= {s, acc[WIDTH-1:1]}; opA and opB shift right by one; carry <= c; cnt <= cnt+1.
- The edge that processes bit WIDTH-1 (cnt==WIDTH-1) is the final shift. On that edge:
  - Sum <= {s, acc[WIDTH-1:1]}; Cout <= c; go to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Timing: start accepted at edge k → busy=1 after edges k..k+WIDTH-1 → done=1 after edge k+WIDTH. Total latency WIDTH+1 edges from accepting edge to done low.
- busy and done are decoded from registered state; they are never high together.
- start while busy or during DONE is ignored; it is not queued. Back-to-back start is accepted in the first IDLE cycle after DONE.
- Sum/Cout change only on the final-shift edge or on reset; they hold across IDLE and subsequent starts until the next completion.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits wide.
  - Sum is modulo 2^WIDTH; overflow is reported only via Cout.
  - WIDTH=1 degenerates to a single SHIFT cycle.
- rst asserted mid-operation (any state) aborts on that edge: all outputs return to reset values and no done pulse is generated.
- rst has priority over start on the same edge.

Decomposition:
- Shared package arith_pkg holds:
  - FSM state encoding typedef (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the counter-width helper constant.
- One sub-module is natural: fa_cell (inputs a, b, ci; outputs s, co), gate-level XOR/AND/OR.
  - Instantiated once for the per-bit sum/carry.
  - Reusable by other arithmetic blocks.
- Everything else is in serial_adder.

Test Plan (WIDTH=8):
- Reset, then idle 3 cycles → busy=0, done=0, Sum=8'h00, Cout=0.
- A=8'hFF, B=8'h01, Cin=0, start pulse at edge k → busy high for 8 cycles; done high exactly after edge k+8; Sum=8'h00, Cout=1.
- A=8'h5A, B=8'hA5, Cin=1 → Sum=8'h00, Cout=1. Then A=8'h12, B=8'h34, Cin=0 → Sum=8'h46, Cout=0; previous result held until this done.
- start re-asserted with A=8'h01, B=8'h01 during SHIFT and during DONE → ignored; first result unchanged (8'h46). A start in the following IDLE cycle yields Sum=8'h02.
- Operands changed to 8'h00 one cycle after the accepting edge → result still reflects the originally sampled operands.
- rst asserted 4 cycles into an addition of 8'hF0+8'h0F → next cycle busy=0, done=0, Sum=0, Cout=0. No done pulse follows; a new start behaves normally.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding for bit-serial blocks
// and the bit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Counter must hold values 0..w, hence w+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell built from XOR/AND/OR gates; reusable by any
// arithmetic block that needs a single sum/carry slice.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  wire x_s;
  wire g_s;
  wire p_s;

  xor u_x1 (x_s, a, b);
  xor u_x2 (s, x_s, ci);
  and u_a1 (g_s, a, b);
  and u_a2 (p_s, x_s, ci);
  or  u_o1 (co, g_s, p_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop adds one
// bit per clock LSB first and publishes a held Sum/Cout with a done pulse.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s_s;
  logic             co_s;
  logic [WIDTH-1:0] acc_shift_s;

  fa_cell u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (s_s),
    .co (co_s)
  );

  // A one-bit accumulator has nothing to shift in from above.
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_shift_s = s_s;
  end else begin : g_acc_wn
    assign acc_shift_s = {s_s, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d   = acc_shift_s;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = co_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // Final bit: publish directly so Sum sees the bit just computed.
          sum_d   = acc_shift_s;
          cout_d  = co_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): arithmetic latency model,
// per-cycle compare process and hand-computed result literals.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: an addition takes WIDTH busy cycles, then one done cycle.
  int             m_left;
  logic           m_done;
  logic [WIDTH:0] m_pend;
  logic [WIDTH-1:0] m_sum;
  logic           m_cout;

  logic [WIDTH:0] lit_q[$];
  logic           chk_en  = 1'b0;
  logic           end_req = 1'b0;
  logic           end_ack = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_sum  <= '0;
      m_cout <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_done) begin
        if (start) begin
          m_left <= WIDTH;
          m_pend <= {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        end
      end else if (m_left == 1) begin
        {m_cout, m_sum} <= m_pend;
        m_left <= 0;
        m_done <= 1'b1;
      end else if (m_left > 1) begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: owns the counters.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left != 0));
      check("done", 32'(done), 32'(m_done));
      check("sum", 32'(Sum), 32'(m_sum));
      check("cout", 32'(Cout), 32'(m_cout));
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (m_done) begin
        if (lit_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [WIDTH:0] lit;
          lit = lit_q.pop_front();
          check("literal_result", 32'({Cout, Sum}), 32'(lit));
        end
      end
    end
    if (end_req && !end_ack) begin
      check("results_outstanding", 32'(lit_q.size()), 32'd0);
      end_ack = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic [WIDTH:0] exp);
    A = a; B = b; Cin = ci; start = 1'b1;
    lit_q.push_back(exp);
    cyc();
    start = 1'b0;
    repeat (WIDTH + 1) cyc();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    run_op(8'hFF, 8'h01, 1'b0, 9'h100);
    run_op(8'h5A, 8'hA5, 1'b1, 9'h100);
    run_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // 12+34, with an ignored start held through SHIFT and DONE that is
    // finally accepted in the first IDLE cycle.
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    lit_q.push_back(9'h046);
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    A = 8'h01; B = 8'h01; start = 1'b1;
    lit_q.push_back(9'h002);
    repeat (8) cyc();
    start = 1'b0;
    repeat (WIDTH + 1) cyc();

    // Operands drop to zero right after the accepting edge.
    A = 8'h33; B = 8'h44; Cin = 1'b0; start = 1'b1;
    lit_q.push_back(9'h077);
    cyc();
    start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b1;
    repeat (WIDTH + 1) cyc();

    // Abort 4 cycles into F0+0F; no done may follow.
    A = 8'hF0; B = 8'h0F; Cin = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (WIDTH + 2) cyc();

    run_op(8'h03, 8'h04, 1'b1, 9'h008);
    repeat (2) cyc();

    end_req = 1'b1;
    repeat (4) begin
      if (!end_ack) cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
